// File: rtl/snake_head_step_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// snake_head_step_if - control inputs and head outputs of snake_head_step
// Rev 1.0
// ----------------------------------------------------------------------
interface snake_head_step_if #(
  parameter int X_W = 6,
  parameter int Y_W = 5
);
  logic           start_i;
  logic           pause_i;
  logic [1:0]     dir_i;
  logic [X_W-1:0] head_x_o;
  logic [Y_W-1:0] head_y_o;
  logic           step_o;
  logic           game_over_o;
  logic           running_o;

  modport master (
    output start_i, pause_i, dir_i,
    input  head_x_o, head_y_o, step_o, game_over_o, running_o
  );

  modport slave (
    input  start_i, pause_i, dir_i,
    output head_x_o, head_y_o, step_o, game_over_o, running_o
  );
endinterface
`default_nettype wire

// File: rtl/snake_head_step.sv
`default_nettype none
// ----------------------------------------------------------------------
// snake_head_step - tick-driven snake head mover with wall-collision stop
// Rev 1.0
// ----------------------------------------------------------------------
module snake_head_step #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int TICK_DIV = 5000000,
  parameter int START_X  = 20,
  parameter int START_Y  = 15
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  snake_head_step_if.slave  bus
);

  localparam int CNT_W = $clog2(TICK_DIV);

  localparam logic [CNT_W-1:0] C_TC      = CNT_W'(TICK_DIV - 1);
  localparam logic [X_W-1:0]   C_X_MAX   = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   C_Y_MAX   = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0]   C_START_X = X_W'(START_X);
  localparam logic [Y_W-1:0]   C_START_Y = Y_W'(START_Y);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  state_t         state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [X_W-1:0] head_x_q, head_x_d;
  logic [Y_W-1:0] head_y_q, head_y_d;
  logic           step_q;
  logic           game_over_q;
  logic           running_q;
  logic           hit_wall_d;

  // Candidate head for the current dir; only committed at terminal count.
  always_comb begin
    head_x_d   = head_x_q;
    head_y_d   = head_y_q;
    hit_wall_d = 1'b0;
    case (bus.dir_i)
      2'b00: if (head_x_q == C_X_MAX) hit_wall_d = 1'b1;
             else head_x_d = head_x_q + 1'b1;
      2'b01: if (head_x_q == '0) hit_wall_d = 1'b1;
             else head_x_d = head_x_q - 1'b1;
      2'b10: if (head_y_q == '0) hit_wall_d = 1'b1;
             else head_y_d = head_y_q - 1'b1;
      default: if (head_y_q == C_Y_MAX) hit_wall_d = 1'b1;
               else head_y_d = head_y_q + 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      head_x_q    <= C_START_X;
      head_y_q    <= C_START_Y;
      step_q      <= 1'b0;
      game_over_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (bus.start_i) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (!bus.pause_i) begin
            if (cnt_q != C_TC) begin
              cnt_q <= cnt_q + 1'b1;
            end else begin
              cnt_q <= '0;
              if (hit_wall_d) begin
                state_q     <= S_DEAD;
                game_over_q <= 1'b1;
                running_q   <= 1'b0;
              end else begin
                head_x_q <= head_x_d;
                head_y_q <= head_y_d;
                step_q   <= 1'b1;
              end
            end
          end
        end
        S_DEAD: begin
          cnt_q <= '0;
          if (bus.start_i) begin
            state_q     <= S_RUN;
            head_x_q    <= C_START_X;
            head_y_q    <= C_START_Y;
            game_over_q <= 1'b0;
            running_q   <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cnt_q       <= '0;
          game_over_q <= 1'b0;
          running_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.head_x_o    = head_x_q;
  assign bus.head_y_o    = head_y_q;
  assign bus.step_o      = step_q;
  assign bus.game_over_o = game_over_q;
  assign bus.running_o   = running_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_head_step.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_snake_head_step - scoreboard bench for snake_head_step on an 8x6 grid
// Rev 1.0
// ----------------------------------------------------------------------
module tb_snake_head_step;

  localparam int TICK = 4;
  localparam int BUDGET = 20;

  typedef struct {
    logic [2:0] x;
    logic [2:0] y;
  } pos_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  pos_t sb[$];

  snake_head_step_if #(.X_W(3), .Y_W(3)) bus ();

  snake_head_step #(
    .GRID_W(8), .GRID_H(6), .X_W(3), .Y_W(3),
    .TICK_DIV(TICK), .START_X(4), .START_Y(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advances one negedge at a time until step is seen or the budget runs out.
  task automatic wait_step(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.step_o !== 1'b1 && cyc < BUDGET);
  endtask

  task automatic wait_dead(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.game_over_o !== 1'b1 && cyc < BUDGET);
  endtask

  task automatic push(input int x, input int y);
    pos_t p;
    p.x = 3'(x);
    p.y = 3'(y);
    sb.push_back(p);
  endtask

  // Waits for a step, then pops the scoreboard and compares timing and position.
  task automatic step_and_score(input string name, input int exp_cyc);
    int   cyc;
    pos_t e;
    wait_step(cyc);
    n_cmp++;
    if (cyc !== exp_cyc) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d clks, want %0d", name, cyc, exp_cyc);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s_scoreboard: empty at step", name);
    end else begin
      e = sb.pop_front();
      if ({bus.head_x_o, bus.head_y_o} !== {e.x, e.y}) begin
        n_bad++;
        $display("FAIL %s_head: got (%0d,%0d), want (%0d,%0d)", name,
                 bus.head_x_o, bus.head_y_o, e.x, e.y);
      end
    end
  endtask

  task automatic dead_and_check(input string name, input int x, input int y);
    int cyc;
    wait_dead(cyc);
    n_cmp++;
    if (cyc !== TICK) begin
      n_bad++;
      $display("FAIL %s_dead_latency: got %0d, want %0d", name, cyc, TICK);
    end
    n_cmp++;
    if ({bus.head_x_o, bus.head_y_o, bus.step_o, bus.running_o} !== {3'(x), 3'(y), 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL %s_dead_state: got head (%0d,%0d) step %b run %b, want (%0d,%0d) 0 0",
               name, bus.head_x_o, bus.head_y_o, bus.step_o, bus.running_o, x, y);
    end
  endtask

  task automatic restart(input logic [1:0] d);
    bus.dir_i   = d;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    n_cmp++;
    if ({bus.head_x_o, bus.head_y_o, bus.running_o, bus.game_over_o, bus.step_o} !==
        {3'd4, 3'd3, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL restart: got (%0d,%0d) run %b go %b step %b, want (4,3) 1 0 0",
               bus.head_x_o, bus.head_y_o, bus.running_o, bus.game_over_o, bus.step_o);
    end
  endtask

  task automatic test_reset();
    logic bad;
    n_cmp++;
    if ({bus.head_x_o, bus.head_y_o, bus.step_o, bus.game_over_o, bus.running_o} !==
        {3'd4, 3'd3, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_state: got (%0d,%0d) step %b go %b run %b, want (4,3) 0 0 0",
               bus.head_x_o, bus.head_y_o, bus.step_o, bus.game_over_o, bus.running_o);
    end
    rst_n = 1'b1;
    bus.pause_i = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.running_o !== 1'b0 || bus.step_o !== 1'b0) bad = 1'b1;
    end
    bus.pause_i = 1'b0;
    n_cmp++;
    if (bad !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_hold: got activity %b, want 0", bad);
    end
  endtask

  task automatic test_move_right();
    logic bad;
    restart(2'b00);
    push(5, 3); push(6, 3); push(7, 3);
    repeat (3) step_and_score("right", TICK);
    dead_and_check("right_wall", 7, 3);
    bus.pause_i = 1'b1;
    bus.dir_i   = 2'b01;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if ({bus.head_x_o, bus.head_y_o, bus.game_over_o, bus.step_o} !== {3'd7, 3'd3, 1'b1, 1'b0})
        bad = 1'b1;
    end
    bus.pause_i = 1'b0;
    n_cmp++;
    if (bad !== 1'b0) begin
      n_bad++;
      $display("FAIL dead_frozen: got disturbance %b, want 0", bad);
    end
  endtask

  task automatic test_restart_up();
    restart(2'b10);
    push(4, 2); push(4, 1); push(4, 0);
    repeat (3) step_and_score("up", TICK);
    dead_and_check("top_wall", 4, 0);
  endtask

  task automatic test_pause();
    logic bad;
    restart(2'b00);
    repeat (2) @(negedge clk);
    bus.pause_i = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.step_o !== 1'b0 || bus.running_o !== 1'b1) bad = 1'b1;
    end
    bus.pause_i = 1'b0;
    n_cmp++;
    if (bad !== 1'b0) begin
      n_bad++;
      $display("FAIL pause_hold: got step/run disturbance %b, want 0", bad);
    end
    push(5, 3);
    step_and_score("pause_resume", TICK - 2);
  endtask

  task automatic test_dir_sample();
    bus.dir_i = 2'b01;
    repeat (TICK - 1) @(negedge clk);
    bus.dir_i = 2'b11;
    push(5, 4);
    step_and_score("late_dir", 1);
    @(negedge clk);
    bus.dir_i = 2'b01;
    @(negedge clk);
    bus.dir_i = 2'b11;
    push(5, 5);
    step_and_score("glitch_dir", TICK - 2);
    dead_and_check("bottom_wall", 5, 5);
  endtask

  task automatic test_reset_mid_run();
    logic bad;
    restart(2'b01);
    push(3, 3); push(2, 3);
    step_and_score("left", TICK);
    step_and_score("left", TICK);
    bus.dir_i = 2'b11;
    push(2, 4); push(2, 5);
    step_and_score("down", TICK);
    step_and_score("down", TICK);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.head_x_o, bus.head_y_o, bus.step_o, bus.game_over_o, bus.running_o} !==
        {3'd4, 3'd3, 3'b000}) begin
      n_bad++;
      $display("FAIL midrun_reset: got (%0d,%0d) step %b go %b run %b, want (4,3) 0 0 0",
               bus.head_x_o, bus.head_y_o, bus.step_o, bus.game_over_o, bus.running_o);
    end
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (3 * TICK) begin
      @(negedge clk);
      if (bus.step_o !== 1'b0 || bus.running_o !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: got activity %b, want 0", bad);
    end
  endtask

  task automatic test_start_pause_idle();
    logic bad;
    bus.dir_i   = 2'b00;
    bus.pause_i = 1'b1;
    bus.start_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.running_o !== 1'b1) begin
      n_bad++;
      $display("FAIL start_with_pause: got running %b, want 1", bus.running_o);
    end
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.step_o !== 1'b0 || bus.running_o !== 1'b1) bad = 1'b1;
    end
    bus.start_i = 1'b0;
    bus.pause_i = 1'b0;
    n_cmp++;
    if (bad !== 1'b0) begin
      n_bad++;
      $display("FAIL paused_entry_hold: got disturbance %b, want 0", bad);
    end
    push(5, 3);
    step_and_score("paused_entry", TICK);
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    bus.pause_i = 1'b0;
    bus.dir_i   = 2'b00;
    repeat (2) @(negedge clk);
    test_reset();
    test_move_right();
    test_restart_up();
    test_pause();
    test_dir_sample();
    test_reset_mid_run();
    test_start_pause_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
